// File: rtl/imc_rr.sv
// Round-robin memory controller: arbitrates NUM_PORTS requesters onto one ROM/RAM bus,
// decodes regions, sequences a fixed-latency access and reports per-port faults.
module imc_rr #(
  parameter int                    NUM_PORTS      = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE       = 'h0000_0000,
  parameter int                    ROM_ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = 'h0001_0000,
  parameter int                    RAM_ADDR_WIDTH = 8,
  parameter int                    MEM_LATENCY    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_read_enable,
  input  logic [NUM_PORTS-1:0]             req_write_enable,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_out,
  output logic [NUM_PORTS-1:0]             req_mem_ready,
  output logic [NUM_PORTS-1:0]             req_error,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  output logic                             mem_rom_read_enable,
  output logic                             mem_ram_read_enable,
  output logic                             mem_ram_write_enable,
  input  logic [DATA_WIDTH-1:0]            mem_rom_data_out,
  input  logic [DATA_WIDTH-1:0]            mem_ram_data_out
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND, ERROR} state_t;

  state_t                state_reg, state_next;
  logic [PORT_W-1:0]     last_grant_reg, grant_reg, grant_next;
  logic                  req_found;
  logic [NUM_PORTS-1:0]  req_vec;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  op_read_reg, op_write_reg, rom_sel_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  wait_last;
  logic [DATA_WIDTH-1:0] data_reg [NUM_PORTS];

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_rd, sel_wr, rom_hit, ram_hit, fault;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_arr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_data_out[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg[gi];
    end
  endgenerate

  assign req_vec     = req_read_enable | req_write_enable;
  assign mem_address = addr_reg;
  assign mem_data_in = wdata_reg;
  assign wait_last   = (cnt_reg == CNT_W'(MEM_LATENCY - 1));

  // Scan from the port after the last winner so every requester is reached within NUM_PORTS grants.
  always_comb begin
    int                idx;
    logic [PORT_W-1:0] idx_p;
    grant_next = last_grant_reg;
    req_found  = 1'b0;
    idx        = 0;
    idx_p      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx   = (int'(last_grant_reg) + k) % NUM_PORTS;
      idx_p = PORT_W'(idx);
      if (!req_found && req_vec[idx_p]) begin
        req_found  = 1'b1;
        grant_next = idx_p;
      end
    end
  end

  assign sel_addr  = addr_arr[grant_next];
  assign sel_wdata = wdata_arr[grant_next];
  assign sel_rd    = req_read_enable[grant_next];
  assign sel_wr    = req_write_enable[grant_next];
  assign rom_hit   = (sel_addr[ADDR_WIDTH-1:ROM_ADDR_WIDTH+2] == ROM_BASE[ADDR_WIDTH-1:ROM_ADDR_WIDTH+2]);
  assign ram_hit   = (sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2] == RAM_BASE[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2]);
  assign fault     = !(rom_hit || ram_hit) || (sel_addr[1:0] != 2'b00) ||
                     (sel_wr && rom_hit) || (sel_rd && sel_wr);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next           = state_reg;
    mem_rom_read_enable  = 1'b0;
    mem_ram_read_enable  = 1'b0;
    mem_ram_write_enable = 1'b0;
    req_mem_ready        = '0;
    req_error            = '0;
    case (state_reg)
      IDLE: begin
        if (req_found) state_next = fault ? ERROR : ISSUE;
      end
      ISSUE: begin
        mem_rom_read_enable  = op_read_reg  &&  rom_sel_reg;
        mem_ram_read_enable  = op_read_reg  && !rom_sel_reg;
        mem_ram_write_enable = op_write_reg && !rom_sel_reg;
        state_next           = WAIT;
      end
      WAIT: begin
        if (wait_last) state_next = RESPOND;
      end
      RESPOND: begin
        req_mem_ready[grant_reg] = 1'b1;
        state_next               = IDLE;
      end
      ERROR: begin
        req_mem_ready[grant_reg] = 1'b1;
        req_error[grant_reg]     = 1'b1;
        state_next               = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= PORT_W'(NUM_PORTS - 1);
      grant_reg      <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      op_read_reg    <= 1'b0;
      op_write_reg   <= 1'b0;
      rom_sel_reg    <= 1'b0;
      cnt_reg        <= '0;
      for (int i = 0; i < NUM_PORTS; i++) data_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_found) begin
            grant_reg      <= grant_next;
            last_grant_reg <= grant_next;
            addr_reg       <= sel_addr;
            wdata_reg      <= sel_wdata;
            op_read_reg    <= sel_rd;
            op_write_reg   <= sel_wr;
            rom_sel_reg    <= rom_hit;
            cnt_reg        <= '0;
            // Clearing here makes the zero visible in the same cycle as the error pulse.
            if (fault && sel_rd && !sel_wr) data_reg[grant_next] <= '0;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (wait_last && op_read_reg)
            data_reg[grant_reg] <= rom_sel_reg ? mem_rom_data_out : mem_ram_data_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imc_rr.sv
// Scoreboard bench for imc_rr: latency-1 instance with ROM/RAM models plus a latency-3 instance.
module tb_imc_rr;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    rd_en, wr_en, ready, err;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] din, dout;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_din, rom_q, ram_q;
  logic             rom_re, ram_re, ram_we;

  logic [NP-1:0]    rd_en2, wr_en2, ready2, err2;
  logic [NP*AW-1:0] addr2;
  logic [NP*DW-1:0] din2, dout2;
  logic [AW-1:0]    mem_addr2;
  logic [DW-1:0]    mem_din2, rom_q2, ram_q2;
  logic             rom_re2, ram_re2, ram_we2;

  imc_rr #(.NUM_PORTS(NP), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_read_enable(rd_en), .req_write_enable(wr_en),
    .req_address(addr), .req_data_in(din), .req_data_out(dout),
    .req_mem_ready(ready), .req_error(err),
    .mem_address(mem_addr), .mem_data_in(mem_din),
    .mem_rom_read_enable(rom_re), .mem_ram_read_enable(ram_re), .mem_ram_write_enable(ram_we),
    .mem_rom_data_out(rom_q), .mem_ram_data_out(ram_q)
  );

  imc_rr #(.NUM_PORTS(NP), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_read_enable(rd_en2), .req_write_enable(wr_en2),
    .req_address(addr2), .req_data_in(din2), .req_data_out(dout2),
    .req_mem_ready(ready2), .req_error(err2),
    .mem_address(mem_addr2), .mem_data_in(mem_din2),
    .mem_rom_read_enable(rom_re2), .mem_ram_read_enable(ram_re2), .mem_ram_write_enable(ram_we2),
    .mem_rom_data_out(rom_q2), .mem_ram_data_out(ram_q2)
  );

  logic [31:0] rom  [256];
  logic [31:0] ram  [256];
  logic [31:0] ram2 [256];
  logic [31:0] p1, p2, p3;

  always @(posedge clk) begin
    if (rom_re) rom_q <= rom[mem_addr[9:2]];
    if (ram_re) ram_q <= ram[mem_addr[9:2]];
    if (ram_we) ram[mem_addr[9:2]] <= mem_din;
  end

  // Data appears only in the third cycle after the enable, zero otherwise.
  always @(posedge clk) begin
    p1 <= ram_re2 ? ram2[mem_addr2[9:2]] : 32'h0;
    p2 <= p1;
    p3 <= p2;
  end
  assign ram_q2 = p3;
  assign rom_q2 = 32'hBAD0_BAD0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t        sb[$];
  exp_t        ex;
  logic [31:0] exp_out [NP];

  int checks = 0;
  int passed = 0;

  int          en_cyc, en_cnt, rdy_cyc, rdy_port, rdy_cnt;
  logic [2:0]  en_kind;
  logic        o_err, addr_moved;
  logic [31:0] o_data, o_ma, o_md;

  task automatic set_req(input int p, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    rd_en[p]          = rd;
    wr_en[p]          = wr;
    addr[p*AW +: AW]  = a;
    din[p*DW +: DW]   = d;
  endtask

  // Reference model of each port's read-data register, pushed to the scoreboard.
  task automatic expect_txn(input int p, input logic rd, input logic wr,
                            input logic e, input logic [31:0] rdata);
    if (rd && !wr) exp_out[p] = e ? 32'h0 : rdata;
    sb.push_back('{p, exp_out[p], e});
  endtask

  // Observes one transaction of the latency-1 instance; cycle 0 is the sampling edge.
  task automatic run_txn(input int p);
    en_cyc = -1; en_cnt = 0; en_kind = 3'b000; rdy_cyc = -1; rdy_port = -1; rdy_cnt = 0;
    o_err = 1'bx; o_data = 'x; o_ma = 'x; o_md = 'x; addr_moved = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (en_cyc > 0 && rdy_cyc < 0 && mem_addr !== o_ma) addr_moved = 1'b1;
      if (rom_re || ram_re || ram_we) begin
        en_cnt += int'(rom_re) + int'(ram_re) + int'(ram_we);
        if (en_cyc < 0) begin
          en_cyc = c; en_kind = {rom_re, ram_re, ram_we}; o_ma = mem_addr; o_md = mem_din;
        end
      end
      rdy_cnt += $countones(ready);
      if (ready != 0 && rdy_cyc < 0) begin
        rdy_cyc = c;
        for (int q = 0; q < NP; q++) if (ready[q]) rdy_port = q;
        o_err  = err[rdy_port];
        o_data = dout[rdy_port*DW +: DW];
        rd_en[p] = 1'b0;
        wr_en[p] = 1'b0;
      end
      if (rdy_cyc > 0 && c == rdy_cyc + 1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_en = '0; wr_en = '0; addr = '0; din = '0;
    rd_en2 = '0; wr_en2 = '0; addr2 = '0; din2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dout !== '0) $display("FAIL reset_dout got %h want 0", dout); else passed++;
    checks++; if (ready !== '0) $display("FAIL reset_ready got %b want 0", ready); else passed++;
    checks++; if (err !== '0) $display("FAIL reset_err got %b want 0", err); else passed++;
    checks++; if ({rom_re, ram_re, ram_we} !== 3'b000) $display("FAIL reset_en got %b want 000", {rom_re, ram_re, ram_we}); else passed++;
    checks++; if (mem_addr !== '0 || mem_din !== '0) $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_din); else passed++;
    checks++; if (dout2 !== '0 || ready2 !== '0) $display("FAIL reset_dut3 got %h/%b want 0/0", dout2, ready2); else passed++;
    for (int i = 0; i < NP; i++) exp_out[i] = 32'h0;
    reset = 1'b0;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    expect_txn(0, 1'b1, 1'b0, 1'b0, rom[2]);
    run_txn(0);
    ex = sb.pop_front();
    checks++; if (en_cyc !== 1 || en_kind !== 3'b100) $display("FAIL single_en got cyc %0d kind %b want 1/100", en_cyc, en_kind); else passed++;
    checks++; if (en_cnt !== 1) $display("FAIL single_en_cnt got %0d want 1", en_cnt); else passed++;
    checks++; if (o_ma !== 32'h8) $display("FAIL single_addr got %h want 8", o_ma); else passed++;
    checks++; if (rdy_cyc !== 3 || rdy_cnt !== 1) $display("FAIL single_ready got cyc %0d cnt %0d want 3/1", rdy_cyc, rdy_cnt); else passed++;
    checks++; if (rdy_port !== ex.port || o_err !== ex.err || o_data !== ex.data)
      $display("FAIL single_sb got p%0d e%b %h want p%0d e%b %h", rdy_port, o_err, o_data, ex.port, ex.err, ex.data); else passed++;
    $display("txn single_read port %0d data %h ready cycle %0d", rdy_port, o_data, rdy_cyc);
  endtask

  task automatic test_ram_write_read();
    set_req(1, 1'b0, 1'b1, 32'h1_0004, 32'hDEAD_BEEF);
    expect_txn(1, 1'b0, 1'b1, 1'b0, 32'h0);
    run_txn(1);
    ex = sb.pop_front();
    checks++; if (en_cyc !== 1 || en_kind !== 3'b001 || en_cnt !== 1) $display("FAIL wr_en got cyc %0d kind %b cnt %0d want 1/001/1", en_cyc, en_kind, en_cnt); else passed++;
    checks++; if (o_ma[9:2] !== 8'd1 || o_md !== 32'hDEAD_BEEF) $display("FAIL wr_bus got idx %0d data %h want 1/deadbeef", o_ma[9:2], o_md); else passed++;
    checks++; if (addr_moved !== 1'b0) $display("FAIL wr_addr_stable got moved %b want 0", addr_moved); else passed++;
    checks++; if (rdy_cyc !== 3) $display("FAIL wr_ready got %0d want 3", rdy_cyc); else passed++;
    checks++; if (rdy_port !== ex.port || o_err !== ex.err || o_data !== ex.data)
      $display("FAIL wr_sb got p%0d e%b %h want p%0d e%b %h", rdy_port, o_err, o_data, ex.port, ex.err, ex.data); else passed++;
    $display("txn ram_write port %0d idx %0d data %h", rdy_port, o_ma[9:2], o_md);

    set_req(1, 1'b1, 1'b0, 32'h1_0004, 32'h0);
    expect_txn(1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    run_txn(1);
    ex = sb.pop_front();
    checks++; if (en_cyc !== 1 || en_kind !== 3'b010) $display("FAIL rd_en got cyc %0d kind %b want 1/010", en_cyc, en_kind); else passed++;
    checks++; if (rdy_cyc !== 3) $display("FAIL rd_ready got %0d want 3", rdy_cyc); else passed++;
    checks++; if (rdy_port !== ex.port || o_err !== ex.err || o_data !== ex.data)
      $display("FAIL rd_sb got p%0d e%b %h want p%0d e%b %h", rdy_port, o_err, o_data, ex.port, ex.err, ex.data); else passed++;
    checks++; if (dout[0 +: DW] !== exp_out[0]) $display("FAIL rd_port0_kept got %h want %h", dout[0 +: DW], exp_out[0]); else passed++;
    $display("txn ram_read port %0d data %h", rdy_port, o_data);
  endtask

  task automatic test_fairness();
    int n, prev;
    n = 0; prev = 0;
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'hC, 32'h0);
    for (int k = 0; k < 2; k++) begin
      expect_txn(0, 1'b1, 1'b0, 1'b0, rom[2]);
      expect_txn(1, 1'b1, 1'b0, 1'b0, rom[3]);
    end
    @(posedge clk);
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (ready != 0) begin
        rdy_port = -1;
        for (int q = 0; q < NP; q++) if (ready[q]) rdy_port = q;
        ex = sb.pop_front();
        checks++; if (rdy_port !== ex.port || err[rdy_port] !== ex.err || dout[rdy_port*DW +: DW] !== ex.data)
          $display("FAIL fair_sb%0d got p%0d e%b %h want p%0d e%b %h", n, rdy_port, err[rdy_port], dout[rdy_port*DW +: DW], ex.port, ex.err, ex.data); else passed++;
        checks++; if (c - prev !== ((n == 0) ? 3 : 4)) $display("FAIL fair_spacing%0d got %0d want %0d", n, c - prev, (n == 0) ? 3 : 4); else passed++;
        $display("txn fairness grant %0d port %0d cycle %0d", n, rdy_port, c);
        prev = c;
        n++;
        if (n == 4) begin rd_en = '0; end
      end
    end
    rd_en = '0;
    checks++; if (n !== 4) $display("FAIL fair_count got %0d want 4", n); else passed++;
    while (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
  endtask

  task automatic test_faults();
    int          fp  [3] = '{0, 1, 0};
    logic        frd [3] = '{1'b0, 1'b1, 1'b1};
    logic        fwr [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] fa  [3] = '{32'h0, 32'h2_0000, 32'h1_0002};
    for (int i = 0; i < 3; i++) begin
      set_req(fp[i], frd[i], fwr[i], fa[i], 32'h1234_5678);
      expect_txn(fp[i], frd[i], fwr[i], 1'b1, 32'h0);
      run_txn(fp[i]);
      ex = sb.pop_front();
      checks++; if (rdy_cyc !== 1) $display("FAIL fault%0d_ready got %0d want 1", i, rdy_cyc); else passed++;
      checks++; if (en_cnt !== 0) $display("FAIL fault%0d_enables got %0d want 0", i, en_cnt); else passed++;
      checks++; if (rdy_port !== ex.port || o_err !== ex.err || o_data !== ex.data)
        $display("FAIL fault%0d_sb got p%0d e%b %h want p%0d e%b %h", i, rdy_port, o_err, o_data, ex.port, ex.err, ex.data); else passed++;
      $display("txn fault%0d port %0d addr %h err %b data %h", i, rdy_port, fa[i], o_err, o_data);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd_en = '0;
    @(negedge clk);
    checks++; if (ready !== '0 || err !== '0) $display("FAIL rstmid_ready got %b/%b want 0/0", ready, err); else passed++;
    checks++; if ({rom_re, ram_re, ram_we} !== 3'b000) $display("FAIL rstmid_en got %b want 000", {rom_re, ram_re, ram_we}); else passed++;
    checks++; if (dout !== '0 || mem_addr !== '0) $display("FAIL rstmid_out got %h/%h want 0/0", dout, mem_addr); else passed++;
    for (int i = 0; i < NP; i++) exp_out[i] = 32'h0;
    reset = 1'b0;
    $display("txn reset_mid: transaction dropped");

    set_req(1, 1'b1, 1'b0, 32'hC, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    expect_txn(0, 1'b1, 1'b0, 1'b0, rom[2]);
    expect_txn(1, 1'b1, 1'b0, 1'b0, rom[3]);
    run_txn(0);
    ex = sb.pop_front();
    checks++; if (rdy_cyc !== 3) $display("FAIL rstmid_first_ready got %0d want 3", rdy_cyc); else passed++;
    checks++; if (rdy_port !== ex.port || o_err !== ex.err || o_data !== ex.data)
      $display("FAIL rstmid_first_sb got p%0d e%b %h want p%0d e%b %h", rdy_port, o_err, o_data, ex.port, ex.err, ex.data); else passed++;
    $display("txn after_reset port %0d data %h", rdy_port, o_data);
    run_txn(1);
    ex = sb.pop_front();
    checks++; if (rdy_cyc !== 3) $display("FAIL b2b_ready got %0d want 3", rdy_cyc); else passed++;
    checks++; if (rdy_port !== ex.port || o_err !== ex.err || o_data !== ex.data)
      $display("FAIL b2b_sb got p%0d e%b %h want p%0d e%b %h", rdy_port, o_err, o_data, ex.port, ex.err, ex.data); else passed++;
    $display("txn back_to_back port %0d data %h", rdy_port, o_data);
  endtask

  task automatic test_latency3();
    int          e_c, r_c;
    logic [31:0] r_d;
    e_c = -1; r_c = -1; r_d = 'x;
    rd_en2[0]        = 1'b1;
    addr2[0 +: AW]   = 32'h1_0010;
    sb.push_back('{0, ram2[4], 1'b0});
    @(posedge clk);
    for (int c = 1; c <= 12 && r_c < 0; c++) begin
      @(negedge clk);
      if (ram_re2 && e_c < 0) e_c = c;
      if (ready2[0]) begin r_c = c; r_d = dout2[0 +: DW]; rd_en2[0] = 1'b0; end
    end
    rd_en2 = '0;
    ex = sb.pop_front();
    checks++; if (e_c !== 1) $display("FAIL lat3_en got %0d want 1", e_c); else passed++;
    checks++; if (r_c !== 5) $display("FAIL lat3_ready got %0d want 5", r_c); else passed++;
    checks++; if (r_d !== ex.data || err2[0] !== ex.err) $display("FAIL lat3_data got %h want %h", r_d, ex.data); else passed++;
    $display("txn latency3 port 0 data %h ready cycle %0d", r_d, r_c);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 32'h1000_0000 + i * 32'h0001_0101;
      ram[i]  = 32'h0;
      ram2[i] = 32'h5500_0000 + i;
    end
    rom[2]  = 32'h0050_0093;
    rom[3]  = 32'h00A0_0113;
    ram2[4] = 32'hCAFE_F00D;
    rom_q = '0; ram_q = '0; p1 = '0; p2 = '0; p3 = '0;

    test_reset();
    test_single_read();
    test_ram_write_read();
    test_fairness();
    test_faults();
    test_reset_mid();
    test_latency3();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imc_rr.md
# imc_rr

Parametrised round-robin integrated memory controller serving `NUM_PORTS` requesters (instruction/data MMUs, future DMA or debug masters) over one shared ROM/RAM bus. Sits between the MMUs and the ROM/RAM instances in the SoC top. It arbitrates fairly, decodes ROM/RAM regions from configurable bases, sequences a fixed-latency memory access, and reports decode and permission faults per port.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of requesters (≥1)
- `ADDR_WIDTH`, 32, byte-address width
- `DATA_WIDTH`, 32, word width
- `ROM_BASE`, 32'h0000_0000, ROM region base (aligned to region size)
- `ROM_ADDR_WIDTH`, 8, ROM word-index bits (region = 4·2^ROM_ADDR_WIDTH bytes)
- `RAM_BASE`, 32'h0001_0000, RAM region base (aligned to region size)
- `RAM_ADDR_WIDTH`, 8, RAM word-index bits
- `MEM_LATENCY`, 1, cycles from enable to valid memory data (≥1)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req_read_enable` in NUM_PORTS: per-port read request, held until ready
- `req_write_enable` in NUM_PORTS: per-port write request, held until ready
- `req_address` in NUM_PORTS·ADDR_WIDTH: packed byte addresses, port p at [p·ADDR_WIDTH +: ADDR_WIDTH]
- `req_data_in` in NUM_PORTS·DATA_WIDTH: packed write data
- `req_data_out` out NUM_PORTS·DATA_WIDTH: packed registered read data
- `req_mem_ready` out NUM_PORTS: one-cycle completion pulse
- `req_error` out NUM_PORTS: valid with `req_mem_ready`; 1 = faulted access
- `mem_address` out ADDR_WIDTH: latched byte address (memories slice [N+1:2])
- `mem_data_in` out DATA_WIDTH: latched write data
- `mem_rom_read_enable` out 1
- `mem_ram_read_enable` out 1
- `mem_ram_write_enable` out 1
- `mem_rom_data_out` in DATA_WIDTH
- `mem_ram_data_out` in DATA_WIDTH

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND, ERROR.
- IDLE: request vector = read_enable | write_enable. If nonzero, grant the first requesting port scanning from `last_grant+1` modulo NUM_PORTS; latch port index, address, data, op, region; set `last_grant`. Otherwise stay.
- Decode: ROM hit if address bits [ADDR_WIDTH-1:ROM_ADDR_WIDTH+2] equal ROM_BASE's same bits; RAM analogous. Fault if no hit, addr[1:0]≠0, write to ROM, or read and write both asserted on the granted port. Fault → ERROR; else → ISSUE.
- ISSUE: exactly one of the three memory enables high for this one cycle; → WAIT.
- WAIT: count MEM_LATENCY cycles; in the last one, reads capture the selected region's data into the granted port's `req_data_out` slice; → RESPOND.
- RESPOND: `req_mem_ready[grant]`=1, `req_error`=0; → IDLE.
- ERROR: `req_mem_ready[grant]`=1, `req_error[grant]`=1; faulted reads clear that port's `req_data_out` to 0; → IDLE.
- Writes leave `req_data_out` unchanged. Non-granted ports' outputs are never disturbed.
- `mem_address`/`mem_data_in` stay constant from ISSUE through RESPOND.
- Requester contract: hold request stable until ready; deassert (or present next request) in the cycle after ready.

## Timing
- Reset: state IDLE, `last_grant`=NUM_PORTS-1 (port 0 wins first), all `req_data_out`, `req_mem_ready`, `req_error`, `mem_*` outputs 0. Reset mid-transaction drops it with no ready pulse; all enables low in the cycle after reset asserts.
- Request sampled in IDLE at cycle 0: memory enable in cycle 1, ready (and read data valid) in cycle 2+MEM_LATENCY. Fault: ready+error in cycle 1, no memory enable ever.
- Back-to-back: next IDLE in cycle 3+MEM_LATENCY; peak one access per 3+MEM_LATENCY cycles.
- Simultaneous requests: one grant per IDLE; with all ports continuously requesting, grants rotate 0,1,…,NUM_PORTS-1,0.
- Ready pulses are exactly one cycle; at most one bit of `req_mem_ready` high per cycle.

## Test plan
- Single read: port 0 reads ROM 0x8, ROM word 2 = 0x00500093 → `mem_rom_read_enable` in cycle 1, `req_mem_ready[0]` in cycle 3, data 0x00500093, error 0.
- RAM write/read-back: port 1 writes 0xDEADBEEF to 0x10004, then reads it → `mem_ram_write_enable` 1 cycle with index 1, read returns 0xDEADBEEF, port 0 data unchanged.
- Fairness: both ports hold reads continuously for 4 transactions → grant order 0,1,0,1; no port waits more than one transaction.
- Faults: write to 0x0, read from 0x2_0000, read at 0x10002 → each gives ready+error in cycle 1, no memory enable, read-fault data 0.
- MEM_LATENCY=3 instance: RAM read → ready at cycle 5, capture from cycle-4 memory data.
- Reset mid-operation: assert reset during WAIT → no ready pulse, outputs 0 next cycle; port 0 granted first after release.
